// File: rtl/jtpang_dma_pkg.sv
// Shared FSM type and default sizes for the object DMA responder.
package jtpang_dma_pkg;

    localparam int unsigned DefAw      = 9;
    localparam int unsigned DefWdogLen = 2048;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StSettle,
        StGrant,
        StRelease,
        StAbort
    } dma_state_e;

endpackage

// File: rtl/jtpang_dma_resp_if.sv
// Object engine <-> responder DMA bus: request/grant handshake plus the byte read path.
interface jtpang_dma_resp_if
    import jtpang_dma_pkg::*;
#(
    parameter int unsigned AW = DefAw
) ();

    logic          busrq;
    logic          busak_n;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_din;
    logic          dma_active;

    modport master (
        output busrq,
        output dma_addr,
        input  busak_n,
        input  dma_din,
        input  dma_active
    );

    modport slave (
        input  busrq,
        input  dma_addr,
        output busak_n,
        output dma_din,
        output dma_active
    );

endinterface

// File: rtl/jtframe_dual_ram.sv
// Dual-port byte RAM, registered reads on both ports, read-before-write on a shared address.
module jtframe_dual_ram #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 9
) (
    input  logic          rst,
    input  logic          clk0,
    input  logic [DW-1:0] data0,
    input  logic [AW-1:0] addr0,
    input  logic          we0,
    output logic [DW-1:0] q0,
    input  logic          clk1,
    input  logic [DW-1:0] data1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    output logic [DW-1:0] q1
);

    logic [DW-1:0] mem [2**AW];

    // Both ports run from the same clock here, so all writes share one process.
    always_ff @(posedge clk0) begin
        if (we0) mem[addr0] <= data0;
        if (we1) mem[addr1] <= data1;
    end

    always_ff @(posedge clk0) begin
        if (rst) q0 <= '0;
        else     q0 <= mem[addr0];
    end

    always_ff @(posedge clk1) begin
        if (rst) q1 <= '0;
        else     q1 <= mem[addr1];
    end

endmodule

// File: rtl/jtpang_dma_resp.sv
// Object DMA responder: halts the Z80 via BUSRQ/BUSAK and grants the object RAM to the engine.
// Optional grant watchdog and wdog_flag output enabled by JTPANG_DMA_WDOG_EN.
module jtpang_dma_resp
    import jtpang_dma_pkg::*;
#(
    parameter int unsigned AW        = DefAw,
    parameter int unsigned GRANT_DLY = 2
`ifdef JTPANG_DMA_WDOG_EN
    ,
    parameter int unsigned WDOG_LEN  = DefWdogLen
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_we,
    input  logic          objram_cs,
    output logic [7:0]    cpu_din,
    output logic          cpu_busrq_n,
    input  logic          cpu_busak_n,
`ifdef JTPANG_DMA_WDOG_EN
    output logic          wdog_flag,
`endif
    jtpang_dma_resp_if.slave dma
);

    localparam int unsigned CntW = $clog2(GRANT_DLY + 2);

    dma_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          busrq_n_q, busrq_n_d;
    logic          wdog_fire, req_block;
    logic          cpu_wr;

    assign cpu_wr          = objram_cs & cpu_we & cpu_cen & (state_q != StGrant);
    assign cpu_busrq_n     = busrq_n_q;
    assign dma.busak_n     = (state_q != StGrant);
    assign dma.dma_active  = (state_q == StGrant);

`ifdef JTPANG_DMA_WDOG_EN
    localparam int unsigned WcW = $clog2(WDOG_LEN + 1);

    logic [WcW-1:0] wcnt_q;
    logic           block_q, flag_q;

    assign wdog_fire = (state_q == StGrant) && (wcnt_q == WcW'(WDOG_LEN - 1));
    assign req_block = block_q;
    assign wdog_flag = flag_q;

    // After a forced release the initiator must drop busrq before it can be served again.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q  <= '0;
            block_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            wcnt_q <= (state_q == StGrant) ? wcnt_q + WcW'(1) : '0;
            if (wdog_fire) begin
                flag_q  <= 1'b1;
                block_q <= 1'b1;
            end else if (!dma.busrq) begin
                block_q <= 1'b0;
            end
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign req_block = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busrq_n_d = busrq_n_q;
        unique case (state_q)
            StIdle: begin
                if (dma.busrq && !req_block) begin
                    busrq_n_d = 1'b0;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (!dma.busrq) begin
                    state_d = StAbort;
                end else if (cpu_cen && !cpu_busak_n) begin
                    cnt_d   = CntW'(GRANT_DLY);
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!dma.busrq) begin
                    state_d = StAbort;
                end else if (cnt_q == '0) begin
                    state_d = StGrant;
                end else if (cpu_cen) begin
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) state_d = StGrant;
                end
            end
            StGrant: begin
                if (!dma.busrq || wdog_fire) state_d = StRelease;
            end
            StRelease, StAbort: begin
                busrq_n_d = 1'b1;
                if (cpu_busak_n) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busrq_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busrq_n_q <= busrq_n_d;
        end
    end

    jtframe_dual_ram #(
        .DW (8),
        .AW (AW)
    ) u_objram (
        .rst   (rst),
        .clk0  (clk),
        .data0 (cpu_dout),
        .addr0 (cpu_addr),
        .we0   (cpu_wr),
        .q0    (cpu_din),
        .clk1  (clk),
        .data1 (8'd0),
        .addr1 (dma.dma_addr),
        .we1   (1'b0),
        .q1    (dma.dma_din)
    );

endmodule

// File: tb/tb_jtpang_dma_resp.sv
// Randomised bench for jtpang_dma_resp against a RAM array model and a Z80 BUSAK model.
module tb_jtpang_dma_resp;

    localparam int unsigned AW       = 9;
    localparam int unsigned Words    = 1 << AW;
    localparam int unsigned GrantDly = 2;
`ifdef JTPANG_DMA_WDOG_EN
    localparam int unsigned WdogLen    = 64;
    localparam int unsigned SweepChunk = 32;
`else
    localparam int unsigned SweepChunk = 512;
`endif

    logic          clk = 1'b0;
    logic          rst, cpu_cen, cpu_we, objram_cs, cpu_busak_n;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_dout, cpu_din;
    logic          cpu_busrq_n;
`ifdef JTPANG_DMA_WDOG_EN
    logic          wdog_flag;
`endif

    jtpang_dma_resp_if #(.AW(AW)) dma_bus ();

    jtpang_dma_resp #(
        .AW        (AW),
        .GRANT_DLY (GrantDly)
`ifdef JTPANG_DMA_WDOG_EN
        ,
        .WDOG_LEN  (WdogLen)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_cen     (cpu_cen),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .cpu_we      (cpu_we),
        .objram_cs   (objram_cs),
        .cpu_din     (cpu_din),
        .cpu_busrq_n (cpu_busrq_n),
        .cpu_busak_n (cpu_busak_n),
`ifdef JTPANG_DMA_WDOG_EN
        .wdog_flag   (wdog_flag),
`endif
        .dma         (dma_bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ref_mem [Words];
    bit         granted;
    bit         cen_seen;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_cen(input bit cen);
        cpu_cen  = cen;
        cen_seen = cen;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        step_cen($urandom_range(0, 2) == 0);
    endtask

    // A write lands only when the model says the bus is not granted.
    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_dout  = d;
        objram_cs = 1'b1;
        cpu_we    = 1'b1;
        step_cen(1'b1);
        objram_cs = 1'b0;
        cpu_we    = 1'b0;
        if (!granted) ref_mem[a] = d;
    endtask

    // Z80 asserts BUSAK ack_ticks cpu_cen ticks after BUSRQ; grant expected GrantDly ticks
    // after the tick on which BUSAK is first seen.
    task automatic open_grant(input int unsigned ack_ticks);
        int unsigned seen = 0;
        int remaining = -1;
        int cyc = 0, exp_at = -1, got_at = -1;
        bit ack_now;
        dma_bus.busrq = 1'b1;
        step();
        check_eq("req_busrq_n", cpu_busrq_n, 0);
        while (cyc < 200 && got_at < 0) begin
            ack_now = !cpu_busak_n;
            step();
            cyc++;
            if (cen_seen) begin
                if (remaining > 0) begin
                    remaining--;
                    if (remaining == 0) exp_at = cyc;
                end else if (remaining < 0 && ack_now) begin
                    remaining = GrantDly;
                end
                if (seen < ack_ticks) begin
                    seen++;
                    if (seen == ack_ticks) cpu_busak_n = 1'b0;
                end
            end
            if (!dma_bus.busak_n) got_at = cyc;
        end
        check_eq("grant_latency", got_at, exp_at);
        check_eq("grant_active", dma_bus.dma_active, 1);
        granted = 1'b1;
    endtask

    task automatic close_grant(input bit rereq);
        dma_bus.busrq = 1'b0;
        step();
        check_eq("rel_busak_n", dma_bus.busak_n, 1);
        check_eq("rel_active", dma_bus.dma_active, 0);
        granted = 1'b0;
        step();
        check_eq("rel_busrq_n", cpu_busrq_n, 1);
        if (rereq) dma_bus.busrq = 1'b1;
        repeat ($urandom_range(0, 3)) begin
            step();
            if (rereq) check_eq("rel_hold", cpu_busrq_n, 1);
        end
        cpu_busak_n = 1'b1;
        step();
        if (rereq) begin
            check_eq("rel_idle", cpu_busrq_n, 1);
            step();
            check_eq("rel_rearm", cpu_busrq_n, 0);
            dma_bus.busrq = 1'b0;
            step();
            step();
        end
    endtask

    task automatic dma_read(input logic [AW-1:0] a, input string tag);
        dma_bus.dma_addr = a;
        step();
        check_eq(tag, dma_bus.dma_din, ref_mem[a]);
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, input string tag);
        cpu_addr = a;
        step();
        check_eq(tag, cpu_din, ref_mem[a]);
    endtask

    initial begin
        logic [7:0]    old;
        logic [AW-1:0] a;
        int            gcnt;

        rst = 1'b1; cpu_cen = 1'b0; cpu_we = 1'b0; objram_cs = 1'b0; cpu_busak_n = 1'b1;
        cpu_addr = '0; cpu_dout = '0; dma_bus.busrq = 1'b0; dma_bus.dma_addr = '0;
        granted = 1'b0;
        repeat (3) step();
        check_eq("rst_busrq_n", cpu_busrq_n, 1);
        check_eq("rst_busak_n", dma_bus.busak_n, 1);
        check_eq("rst_active", dma_bus.dma_active, 0);
        check_eq("rst_cpu_din", cpu_din, 0);
        check_eq("rst_dma_din", dma_bus.dma_din, 0);
`ifdef JTPANG_DMA_WDOG_EN
        check_eq("rst_wdog", wdog_flag, 0);
`endif
        rst = 1'b0;
        step();

        // Write outside grant, then read it back through the DMA port
        cpu_write(9'h1FF, 8'hA5);
        dma_bus.dma_addr = 9'h1FF;
        open_grant(3);
        dma_read(9'h1FF, "first_byte");
        close_grant(1'b0);

        // Fill the whole table and sweep it
        for (int i = 0; i < Words; i++) cpu_write(AW'(i), 8'(i) ^ 8'h3C);
        for (int base = 0; base < Words; base += SweepChunk) begin
            open_grant($urandom_range(1, 4));
            for (int i = base; i < base + SweepChunk; i++) dma_read(AW'(i), "sweep");
            close_grant(1'b0);
        end

        // Write during grant is dropped; 511 then 0 reads normally
        open_grant($urandom_range(1, 4));
        cpu_write(9'h010, 8'h77);
        dma_read(9'h010, "grant_wr_dma");
        dma_read(9'h1FF, "wrap_hi");
        dma_read(9'h000, "wrap_lo");
        cpu_read(9'h010, "grant_cpu_din");
        close_grant(1'b1);
        cpu_read(9'h010, "dropped_wr");

        // Same-address CPU write and DMA read outside grant sees old data
        a = AW'($urandom_range(0, Words - 1));
        old = ref_mem[a];
        dma_bus.dma_addr = a;
        cpu_write(a, ~old);
        check_eq("rbw_dma_old", dma_bus.dma_din, old);
        check_eq("rbw_cpu_old", cpu_din, old);
        step();
        check_eq("rbw_dma_new", dma_bus.dma_din, ref_mem[a]);

        // Random rounds
        for (int r = 0; r < 6; r++) begin
            repeat (8) cpu_write(AW'($urandom_range(0, Words - 1)), 8'($urandom));
            open_grant($urandom_range(1, 5));
            repeat (12) dma_read(AW'($urandom_range(0, Words - 1)), "rand_dma");
            close_grant(r[0]);
            repeat (4) cpu_read(AW'($urandom_range(0, Words - 1)), "rand_cpu");
        end

        // Abort: busrq drops before BUSAK, Z80 acks late
        dma_bus.busrq = 1'b1;
        step_cen(1'b0);
        check_eq("abort_req", cpu_busrq_n, 0);
        dma_bus.busrq = 1'b0;
        cpu_busak_n = 1'b0;
        step_cen(1'b0);
        check_eq("abort_busak_n", dma_bus.busak_n, 1);
        dma_bus.busrq = 1'b1;
        repeat (3) begin
            step();
            check_eq("abort_hold_busak", dma_bus.busak_n, 1);
            check_eq("abort_hold_busrq", cpu_busrq_n, 1);
        end
        cpu_busak_n = 1'b1;
        step();
        check_eq("abort_idle", cpu_busrq_n, 1);
        step();
        check_eq("abort_rearm", cpu_busrq_n, 0);
        dma_bus.busrq = 1'b0;
        step();
        step();

        // Reset mid-grant
        open_grant(2);
        dma_read(AW'($urandom_range(0, Words - 1)), "pre_rst");
        rst = 1'b1;
        step();
        check_eq("mrst_busak_n", dma_bus.busak_n, 1);
        check_eq("mrst_busrq_n", cpu_busrq_n, 1);
        check_eq("mrst_active", dma_bus.dma_active, 0);
        check_eq("mrst_dma_din", dma_bus.dma_din, 0);
        check_eq("mrst_cpu_din", cpu_din, 0);
        rst = 1'b0; dma_bus.busrq = 1'b0; cpu_busak_n = 1'b1; granted = 1'b0;
        step();

        // busrq together with rst: rst wins
        dma_bus.busrq = 1'b1;
        rst = 1'b1;
        step();
        check_eq("rst_wins", cpu_busrq_n, 1);
        rst = 1'b0;
        step();
        check_eq("post_rst_req", cpu_busrq_n, 0);
        dma_bus.busrq = 1'b0;
        step();
        step();

`ifdef JTPANG_DMA_WDOG_EN
        // Watchdog forces release with busrq still high
        open_grant(2);
        gcnt = 1;
        while (gcnt < 200 && !dma_bus.busak_n) begin
            step();
            if (!dma_bus.busak_n) gcnt++;
        end
        granted = 1'b0;
        check_eq("wdog_len", gcnt, WdogLen);
        check_eq("wdog_flag", wdog_flag, 1);
        step();
        check_eq("wdog_busrq_n", cpu_busrq_n, 1);
        cpu_busak_n = 1'b1;
        repeat (8) begin
            step();
            check_eq("wdog_no_regrant", cpu_busrq_n, 1);
        end
        dma_bus.busrq = 1'b0;
        step();
        dma_bus.busrq = 1'b1;
        step();
        check_eq("wdog_rearm", cpu_busrq_n, 0);
        dma_bus.busrq = 1'b0;
        step();
        step();
        check_eq("wdog_sticky", wdog_flag, 1);
`else
        gcnt = 0;
        check_eq("idle_busak_n", dma_bus.busak_n, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
